// File: rtl/edit_mode_ctrl.sv
// edit_mode_ctrl: one-button run/edit controller with N editable fields.
// A long press enters EDIT, short presses step through the fields (the
// press after the last field returns to RUN), and a quiet period ends
// editing on its own. Also produces the flash blanking mask for the
// field being edited.
//
// Handshake note: key_n is a level (already synchronised/debounced) and
// activity is a single-cycle strobe; neither has a ready/valid exchange.
// Every output is a combinational decode of registered state.
module edit_mode_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_FIELDS   = 3,
    parameter int HOLD_MS    = 1000,
    parameter int TIMEOUT_S  = 10,
    parameter int FLASH_HZ   = 2,
    parameter int FLASH_DUTY = 80,
    localparam int FW        = $clog2(N_FIELDS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_n,
    input  logic                activity,
    output logic                run_en,
    output logic                editing,
    output logic [FW-1:0]       field,
    output logic [N_FIELDS-1:0] field_sel,
    output logic [N_FIELDS-1:0] blank,
    output logic [1:0]          state_dbg
);

    // 64-bit intermediates: CLK_HZ*HOLD_MS overflows 32 bits at default values.
    localparam longint HOLD_L    = longint'(CLK_HZ) * longint'(HOLD_MS) / 64'd1000;
    localparam longint TIMEOUT_L = longint'(CLK_HZ) * longint'(TIMEOUT_S);
    localparam int     HOLD_CYC    = int'(HOLD_L);
    localparam int     TIMEOUT_CYC = int'(TIMEOUT_L);
    localparam int     FLASH_CYC   = CLK_HZ / FLASH_HZ;
    localparam int     ON_CYC      = int'(longint'(FLASH_CYC) * longint'(FLASH_DUTY) / 64'd100);

    localparam int HOLD_W = (HOLD_CYC > 1)    ? $clog2(HOLD_CYC)    : 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int PH_W   = (FLASH_CYC > 1)   ? $clog2(FLASH_CYC)   : 1;

    localparam logic [HOLD_W-1:0] HOLD_T = HOLD_W'(HOLD_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_T = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [PH_W-1:0]   PH_T   = PH_W'(FLASH_CYC - 1);
    // One extra bit so a 100 % duty (ON_CYC == FLASH_CYC) still fits.
    localparam logic [PH_W:0]     ON_V   = (PH_W + 1)'(ON_CYC);
    localparam logic [FW-1:0]     LAST_F = FW'(N_FIELDS);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ARM  = 2'd1,
        EDIT = 2'd2
    } state_t;

    state_t            state;
    logic              key_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [PH_W-1:0]   phase;
    logic              press;
    logic              on;

    assign press     = key_prev & ~key_n;
    assign editing   = (state == EDIT);
    assign run_en    = ~editing;
    assign state_dbg = state;
    assign on        = ({1'b0, phase} < ON_V);
    assign blank     = field_sel & {N_FIELDS{~on}};

    // One-hot decode of the active field; all zero outside EDIT.
    always_comb begin
        field_sel = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            field_sel[i] = editing && (field == FW'(i + 1));
        end
    end

    // Mode FSM with hold, inactivity and flash-phase counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            field    <= '0;
            hold_cnt <= '0;
            idle_cnt <= '0;
            phase    <= '0;
            key_prev <= 1'b1;
        end else begin
            key_prev <= key_n;
            case (state)
                RUN: begin
                    if (press) begin
                        state    <= ARM;
                        hold_cnt <= '0;
                    end
                end
                ARM: begin
                    if (key_n) begin
                        state <= RUN;
                    end else if (hold_cnt == HOLD_T) begin
                        state    <= EDIT;
                        field    <= FW'(1);
                        idle_cnt <= '0;
                        phase    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                EDIT: begin
                    phase <= (phase == PH_T) ? '0 : phase + 1'b1;
                    if (press) begin
                        if (field < LAST_F) begin
                            field    <= field + 1'b1;
                            idle_cnt <= '0;
                            phase    <= '0;
                        end else begin
                            state <= RUN;
                            field <= '0;
                        end
                    end else if (idle_cnt == IDLE_T) begin
                        state <= RUN;
                        field <= '0;
                    end else if (activity) begin
                        // Restart the flash so the field stays visible while adjusted.
                        idle_cnt <= '0;
                        phase    <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    field <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edit_mode_ctrl.sv
// tb_edit_mode_ctrl: directed bench for edit_mode_ctrl with small timing
// parameters (HOLD_CYC=10, TIMEOUT_CYC=100, FLASH_CYC=10, ON_CYC=8).
// Stimulus pushes expected output words; a negedge monitor pops and compares.
module tb_edit_mode_ctrl;

  localparam int W = 12;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_EDIT = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic activity;
  logic run_en;
  logic editing;
  logic [1:0] field;
  logic [2:0] field_sel;
  logic [2:0] blank;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  edit_mode_ctrl #(
    .CLK_HZ     (100),
    .N_FIELDS   (3),
    .HOLD_MS    (100),
    .TIMEOUT_S  (1),
    .FLASH_HZ   (10),
    .FLASH_DUTY (80)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .activity  (activity),
    .run_en    (run_en),
    .editing   (editing),
    .field     (field),
    .field_sel (field_sel),
    .blank     (blank),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;
  string        mon_n;

  // Expected word: {state, run_en, editing, field, field_sel, blank}.
  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic [1:0] fld,
                                      input logic [2:0] bl);
    logic [2:0] sel;
    sel = 3'b000;
    if (st == S_EDIT && fld != 2'd0) sel = 3'b001 << (fld - 2'd1);
    return {st, (st != S_EDIT), (st == S_EDIT), fld, sel, bl};
  endfunction

  // Flash mask for ON_CYC=8 of FLASH_CYC=10.
  function automatic logic [2:0] fl(input int ph, input logic [2:0] mask);
    return (ph >= 8) ? mask : 3'b000;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {state_dbg, run_en, editing, field, field_sel, blank};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (t=%0t)", mon_n, mon_a, mon_e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [1:0] st, input logic [1:0] fld,
                            input logic [2:0] bl);
    exp_q.push_back(mk(st, fld, bl));
    name_q.push_back(n);
  endtask

  // Long press from RUN: 11 low samples, ends in EDIT field 1, key still held.
  task automatic enter_edit();
    key_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("enter_arm", S_ARM, 2'd0, 3'b000);
    end
    step();
    expect_out("enter_edit", S_EDIT, 2'd1, 3'b000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    activity = 1'b0;
    step();
    step();
    expect_out("reset_state", S_RUN, 2'd0, 3'b000);
    reset = 1'b0;
    step();
    expect_out("idle_run", S_RUN, 2'd0, 3'b000);

    // Short press: ARM then back to RUN, never editing.
    key_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("short_arm", S_ARM, 2'd0, 3'b000);
    end
    key_n = 1'b1;
    step();
    expect_out("short_release", S_RUN, 2'd0, 3'b000);
    step();
    expect_out("short_after", S_RUN, 2'd0, 3'b000);

    // Long press, held key does not advance, then step through fields.
    enter_edit();
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out("held_no_adv", S_EDIT, 2'd1, 3'b000);
    end
    key_n = 1'b1;
    step();
    expect_out("release_f1", S_EDIT, 2'd1, 3'b000);
    key_n = 1'b0;
    step();
    expect_out("adv_f2", S_EDIT, 2'd2, 3'b000);
    key_n = 1'b1;
    step();
    expect_out("release_f2", S_EDIT, 2'd2, 3'b000);
    key_n = 1'b0;
    step();
    expect_out("adv_f3", S_EDIT, 2'd3, 3'b000);
    key_n = 1'b1;
    step();
    expect_out("release_f3", S_EDIT, 2'd3, 3'b000);
    key_n = 1'b0;
    step();
    expect_out("exit_last", S_RUN, 2'd0, 3'b000);
    for (int i = 0; i < 15; i++) begin
      step();
      expect_out("held_after_exit", S_RUN, 2'd0, 3'b000);
    end
    key_n = 1'b1;
    step();
    expect_out("release_run", S_RUN, 2'd0, 3'b000);

    // Flash pattern in field 2 and activity restarts.
    enter_edit();
    key_n = 1'b1;
    step();
    expect_out("flash_f1", S_EDIT, 2'd1, 3'b000);
    key_n = 1'b0;
    step();
    expect_out("flash_adv", S_EDIT, 2'd2, 3'b000);
    key_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      expect_out("flash_cycle", S_EDIT, 2'd2, fl(k % 10, 3'b010));
    end
    activity = 1'b1;
    step();
    activity = 1'b0;
    expect_out("act_ph9", S_EDIT, 2'd2, 3'b000);
    for (int k = 1; k <= 7; k++) begin
      step();
      expect_out("flash_after_act", S_EDIT, 2'd2, 3'b000);
    end
    activity = 1'b1;
    step();
    activity = 1'b0;
    expect_out("act_ph7", S_EDIT, 2'd2, 3'b000);
    step();
    expect_out("act_ph7_next", S_EDIT, 2'd2, 3'b000);

    // Reset in EDIT field 2.
    reset = 1'b1;
    step();
    expect_out("reset_edit", S_RUN, 2'd0, 3'b000);
    reset = 1'b0;
    step();
    expect_out("after_reset_edit", S_RUN, 2'd0, 3'b000);

    // Reset in ARM with hold_cnt=5.
    key_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("arm_before_reset", S_ARM, 2'd0, 3'b000);
    end
    reset = 1'b1;
    key_n = 1'b1;
    step();
    expect_out("reset_arm", S_RUN, 2'd0, 3'b000);
    reset = 1'b0;
    step();
    expect_out("after_reset_arm", S_RUN, 2'd0, 3'b000);

    // Plain timeout: exit exactly 100 edges after entry.
    enter_edit();
    key_n = 1'b1;
    for (int k = 1; k <= 99; k++) begin
      step();
      expect_out("timeout_wait", S_EDIT, 2'd1, fl(k % 10, 3'b001));
    end
    step();
    expect_out("timeout_exit", S_RUN, 2'd0, 3'b000);

    // Timeout with an activity pulse sampled at edge 61: exit at edge 161.
    enter_edit();
    key_n = 1'b1;
    for (int k = 1; k <= 161; k++) begin
      if (k == 61) activity = 1'b1;
      step();
      activity = 1'b0;
      if (k <= 160)
        expect_out("act_timeout_wait", S_EDIT, 2'd1,
                   fl((k <= 60) ? (k % 10) : ((k - 61) % 10), 3'b001));
      else
        expect_out("act_timeout_exit", S_RUN, 2'd0, 3'b000);
    end

    // Press on the same edge the timeout would fire: advance wins, idle restarts.
    enter_edit();
    key_n = 1'b1;
    for (int k = 1; k <= 99; k++) begin
      step();
      expect_out("sim_wait", S_EDIT, 2'd1, fl(k % 10, 3'b001));
    end
    key_n = 1'b0;
    step();
    expect_out("press_at_timeout", S_EDIT, 2'd2, 3'b000);
    for (int k = 1; k <= 99; k++) begin
      step();
      expect_out("sim_idle_restart", S_EDIT, 2'd2, fl(k % 10, 3'b010));
    end
    step();
    expect_out("sim_timeout_exit", S_RUN, 2'd0, 3'b000);
    key_n = 1'b1;
    step();
    expect_out("final_run", S_RUN, 2'd0, 3'b000);
    step();

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edit_mode_ctrl.md
# edit_mode_ctrl

Parametrised edit-mode controller for the clock/display designs. It turns one active-low push button into a run/edit state machine with N editable fields: a long press enters editing, short presses step through the fields, and editing ends automatically after a period with no activity. It also generates the per-field flash blanking mask. It sits between the debounced KEY input and the time counter / seven-segment display blocks.

## Interface
- CLK_HZ, 50_000_000, clock frequency in Hz
- N_FIELDS, 3, number of editable fields (≥1)
- HOLD_MS, 1000, long-press time to enter edit; HOLD_CYC = CLK_HZ*HOLD_MS/1000
- TIMEOUT_S, 10, inactivity time before auto-exit; TIMEOUT_CYC = CLK_HZ*TIMEOUT_S
- FLASH_HZ, 2, flash rate; FLASH_CYC = CLK_HZ/FLASH_HZ
- FLASH_DUTY, 80, visible percentage of each flash period; ON_CYC = FLASH_CYC*FLASH_DUTY/100
- FW, derived, $clog2(N_FIELDS+1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- key_n  in  1  mode button, active-low, already synchronised and debounced
- activity  in  1  one-cycle pulse from the plus/minus logic
- run_en  out  1  high when not editing; gates the timekeeping counter
- editing  out  1  high in EDIT
- field  out  FW  0 in RUN/ARM, 1..N_FIELDS in EDIT
- field_sel  out  N_FIELDS  one-hot: bit field-1 set in EDIT, all zero otherwise
- blank  out  N_FIELDS  bit high means blank that field's digits

## Operation
- Press detection: register key_prev, which resets to 1. press = key_prev & ~key_n.
- States: RUN, ARM, EDIT. Reset values: state=RUN, field=0, hold_cnt=0, idle_cnt=0, phase=0, key_prev=1.
- RUN:
  - press → ARM, hold_cnt←0.
  - A held key without a new press edge never re-arms.
- ARM:
  - key_n=1 → RUN. A short press is ignored.
  - key_n=0 and hold_cnt==HOLD_CYC-1 → EDIT with field←1, idle_cnt←0, phase←0.
  - Otherwise hold_cnt increments.
- EDIT:
  - press with field<N_FIELDS → field+1, idle_cnt←0, phase←0.
  - press with field==N_FIELDS → RUN, field←0.
  - Otherwise, idle_cnt==TIMEOUT_CYC-1 → RUN, field←0.
  - Otherwise, activity → idle_cnt←0 and phase←0, so the field shows steadily while it is being adjusted.
  - Otherwise idle_cnt increments.
  - Priority: press > timeout > activity.
- Flash:
  - In EDIT, phase counts 0..FLASH_CYC-1 and wraps.
  - on = (phase < ON_CYC).
  - blank = field_sel & {N_FIELDS{~on}}. All zero outside EDIT.
- run_en = ~editing. The clock runs during ARM.
- activity is ignored outside EDIT.
- Counter widths: $clog2 of the respective maximum. No counter exceeds its terminal value.

## Timing
- All outputs are combinational decodes of registered state: no added latency beyond the transition edge.
- Entering EDIT:
  - key_n first sampled low at edge 0 → ARM after edge 0.
  - editing rises after edge HOLD_CYC, provided key_n stays low for HOLD_CYC+1 consecutive samples.
- Field advance and exit: take effect one edge after key_n is first sampled low.
- Timeout: idle_cnt reaches TIMEOUT_CYC-1 after TIMEOUT_CYC-1 quiet EDIT cycles. The next edge returns to RUN.
- blank:
  - After entering EDIT, an advance, or activity: 0 for ON_CYC cycles, then 1 for FLASH_CYC-ON_CYC cycles, repeating.
- reset overrides everything on the same edge, including mid-hold and mid-edit.

## Test plan
Bench parameters: CLK_HZ=100, HOLD_MS=100 (HOLD_CYC=10), TIMEOUT_S=1 (TIMEOUT_CYC=100), FLASH_HZ=10, FLASH_DUTY=80 (FLASH_CYC=10, ON_CYC=8), N_FIELDS=3.

- **Short press:** key_n low for 5 cycles, then high → editing stays 0, field=0, run_en=1 throughout.
- **Long press then step:**
  - key_n low for 11 samples → editing=1, field=1, field_sel=001.
  - Three separate presses → field=2 (010), then 3 (100), then RUN (field=0, run_en=1).
  - Keeping the key held after the exit does not re-enter EDIT.
- **Flash:** in EDIT field=2 with no input → blank=000 for 8 cycles, then 010 for 2 cycles, repeating. An activity pulse at phase 9 → blank=000 on the next cycle.
- **Timeout:**
  - Enter EDIT, no input → editing falls exactly 100 cycles after entry.
  - With an activity pulse at cycle 60 → editing falls at cycle 161.
- **Simultaneous events:** a press edge on the same cycle idle_cnt==99 in field 1 → field=2, idle_cnt=0. EDIT does not exit.
- **Reset mid-operation:** assert reset during ARM (hold_cnt=5) and during EDIT field 2 → next cycle state=RUN, field=0, blank=000, run_en=1. A held key does not advance without a new press edge.
